// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the multi-port register file: read ports, two write
// ports, load scoreboard, clear request and sequencer status.
interface regfile_mp_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wa_en;
  logic [AW-1:0]     wa_addr;
  logic [DW-1:0]     wa_data;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic              clr_req;
  logic              init_busy;

  modport master (
    output rd_en, rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set, sb_addr, clr_req,
    input  rd_data, rd_busy, init_busy
  );

  modport slave (
    input  rd_en, rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set, sb_addr, clr_req,
    output rd_data, rd_busy, init_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (B wins), load-use scoreboard and a
// hardware clear sweep. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2**AW;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]    state;
  logic [AW:0]   cnt;
  logic [DEPTH-1:0] sb;
  logic [DW-1:0] mem [DEPTH];
  logic          run;
  logic          wa_ok;
  logic          wb_ok;
  logic          sb_ok;
  logic [AW-1:0] ra;

  assign run           = (state == ST_RUN);
  assign bus.init_busy = (state == ST_CLEAR);

  // Register 0 is hard-wired when ZERO_REG is set: drop its writes and loads.
  assign wa_ok = bus.wa_en  && !((ZERO_REG != 0) && (bus.wa_addr == '0));
  assign wb_ok = bus.wb_en  && !((ZERO_REG != 0) && (bus.wb_addr == '0));
  assign sb_ok = bus.sb_set && !((ZERO_REG != 0) && (bus.sb_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      sb    <= '0;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == (AW+1)'(DEPTH-1))
        state <= ST_RUN;
    end else if (bus.clr_req) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      sb    <= '0;
    end else begin
      // Set is assigned last so a new load outranks a same-cycle writeback.
      if (bus.wb_en)
        sb[bus.wb_addr] <= 1'b0;
      if (sb_ok)
        sb[bus.sb_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[cnt[AW-1:0]] <= '0;
    end else begin
      if (wa_ok)
        mem[bus.wa_addr] <= bus.wa_data;
      if (wb_ok)
        mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra          = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      if (run && bus.rd_en[i] && !((ZERO_REG != 0) && (ra == '0))) begin
`ifdef REGFILE_BYPASS_EN
        if (bus.wb_en && (bus.wb_addr == ra))
          bus.rd_data[i*DW +: DW] = bus.wb_data;
        else if (bus.wa_en && (bus.wa_addr == ra))
          bus.rd_data[i*DW +: DW] = bus.wa_data;
        else
          bus.rd_data[i*DW +: DW] = mem[ra];
        bus.rd_busy[i] = sb[ra] && !(bus.wb_en && (bus.wb_addr == ra));
`else
        bus.rd_data[i*DW +: DW] = mem[ra];
        bus.rd_busy[i]          = sb[ra];
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic
// against an array/scoreboard reference model.
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;
  localparam int ZR    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus();

  regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(ZR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem_m [DEPTH];
  bit            sb_m  [DEPTH];
  int            clr_left;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] raddr(int i);
    return bus.rd_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] exp_rd(int i);
    logic [AW-1:0] a;
    a = raddr(i);
    if (clr_left > 0 || !bus.rd_en[i] || (ZR != 0 && a == 0)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    if (bus.wa_en && bus.wa_addr == a) return bus.wa_data;
`endif
    return mem_m[a];
  endfunction

  function automatic logic exp_busy(int i);
    logic [AW-1:0] a;
    a = raddr(i);
    if (clr_left > 0 || !bus.rd_en[i]) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == a) return 1'b0;
`endif
    return sb_m[a];
  endfunction

  task automatic model_reset();
    clr_left = DEPTH;
    for (int k = 0; k < DEPTH; k++) begin
      mem_m[k] = '0;
      sb_m[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst) return;
    if (clr_left > 0) begin
      clr_left--;
    end else if (bus.clr_req) begin
      model_reset();
    end else begin
      if (bus.wa_en && !(ZR != 0 && bus.wa_addr == 0)) mem_m[bus.wa_addr] = bus.wa_data;
      if (bus.wb_en && !(ZR != 0 && bus.wb_addr == 0)) mem_m[bus.wb_addr] = bus.wb_data;
      if (bus.wb_en) sb_m[bus.wb_addr] = 1'b0;
      if (bus.sb_set && !(ZR != 0 && bus.sb_addr == 0)) sb_m[bus.sb_addr] = 1'b1;
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    #1;
    check("init_busy", {63'd0, bus.init_busy}, {63'd0, (clr_left > 0)});
    for (int i = 0; i < NRD; i++) begin
      check($sformatf("rd_data%0d", i), {32'd0, bus.rd_data[i*DW +: DW]}, {32'd0, exp_rd(i)});
      check($sformatf("rd_busy%0d", i), {63'd0, bus.rd_busy[i]}, {63'd0, exp_busy(i)});
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wa_en   = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_en   = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.sb_set  = 1'b0; bus.sb_addr = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic set_rd(int p, logic [AW-1:0] a);
    bus.rd_en[p] = 1'b1;
    bus.rd_addr[p*AW +: AW] = a;
  endtask

  // Counts cycles with init_busy high (bounded); returns at negedge+1.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      idle();
      #1;
      if (!bus.init_busy) break;
      check("sweep_rd0_zero", {32'd0, bus.rd_data[DW-1:0]}, 64'd0);
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] same_cycle_exp;
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 32'h2222;
`else
    same_cycle_exp = 32'h0;
`endif
    rst = 1'b0;
    idle();
    bus.rd_en   = '0;
    bus.rd_addr = '0;
    set_rd(0, 5'd7);
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_init_busy", {63'd0, bus.init_busy}, 64'd1);
    check("reset_rd_busy", {62'd0, bus.rd_busy}, 64'd0);

    // Initial sweep after reset release.
    @(negedge clk);
    rst = 1'b1;
    count_busy(n);
    check("init_sweep_len", 64'(n), 64'd32);
    check("reg7_after_init", {32'd0, bus.rd_data[DW-1:0]}, 64'd0);
    step();

    // Dual write to the same address: port B wins.
    bus.rd_en = 2'b11;
    set_rd(0, 5'd5); set_rd(1, 5'd6);
    bus.wa_en = 1'b1; bus.wa_addr = 5'd5; bus.wa_data = 32'h1111;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h2222;
    #1 check("dual_wr_same_cycle", {32'd0, bus.rd_data[DW-1:0]}, {32'd0, same_cycle_exp});
    step();
    idle();
    #1 check("dual_wr_portb_wins", {32'd0, bus.rd_data[DW-1:0]}, 64'h2222);
    step();

    // Register 0 stays zero and never goes pending.
    set_rd(0, 5'd0);
    bus.wa_en = 1'b1; bus.wa_addr = 5'd0; bus.wa_data = 32'hDEADBEEF;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hDEADBEEF;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
    #1 check("reg0_same_cycle", {32'd0, bus.rd_data[DW-1:0]}, 64'd0);
    step();
    idle();
    #1;
    check("reg0_next_cycle", {32'd0, bus.rd_data[DW-1:0]}, 64'd0);
    check("reg0_not_busy", {63'd0, bus.rd_busy[0]}, 64'd0);
    step();

    // Scoreboard set / simultaneous set+clear / clear.
    set_rd(0, 5'd9);
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    #1 check("sb9_before_set", {63'd0, bus.rd_busy[0]}, 64'd0);
    step();
    idle();
    #1 check("sb9_set", {63'd0, bus.rd_busy[0]}, 64'd1);
    step();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hA5;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    step();
    idle();
    #1;
    check("sb9_set_wins", {63'd0, bus.rd_busy[0]}, 64'd1);
    check("reg9_loaded", {32'd0, bus.rd_data[DW-1:0]}, 64'hA5);
    step();
    bus.wb_en = 1'b1; bus.wb_addr = 9; bus.wb_data = 32'h5A;
    step();
    idle();
    #1 check("sb9_cleared", {63'd0, bus.rd_busy[0]}, 64'd0);
    step();

    // Clear request wipes array and scoreboard.
    bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'h33;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd4;
    step();
    idle();
    set_rd(0, 5'd3); set_rd(1, 5'd4);
    #1;
    check("reg3_written", {32'd0, bus.rd_data[DW-1:0]}, 64'h33);
    check("reg4_pending", {63'd0, bus.rd_busy[1]}, 64'd1);
    bus.clr_req = 1'b1;
    step();
    count_busy(n);
    check("clr_sweep_len", 64'(n), 64'd32);
    check("reg3_after_clr", {32'd0, bus.rd_data[DW-1:0]}, 64'd0);
    check("reg4_busy_after_clr", {63'd0, bus.rd_busy[1]}, 64'd0);
    step();

    // Reset in the middle of a sweep restarts it.
    bus.clr_req = 1'b1;
    step();
    idle();
    repeat (10) step();
    rst = 1'b0;
    model_reset();
    #1 check("midsweep_rst_busy", {63'd0, bus.init_busy}, 64'd1);
    step();
    step();
    rst = 1'b1;
    count_busy(n);
    check("restart_sweep_len", 64'(n), 64'd32);
    step();

    // Random traffic with a narrow address window to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      bus.rd_en = 2'($urandom);
      for (int p = 0; p < NRD; p++) bus.rd_addr[p*AW +: AW] = 5'($urandom_range(0, 7));
      bus.wa_en   = 1'($urandom);
      bus.wa_addr = 5'($urandom_range(0, 7));
      bus.wa_data = $urandom;
      bus.wb_en   = 1'($urandom);
      bus.wb_addr = 5'($urandom_range(0, 7));
      bus.wb_data = $urandom;
      bus.sb_set  = 1'($urandom);
      bus.sb_addr = 5'($urandom_range(0, 7));
      bus.clr_req = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
